// File: rtl/red_track_coord_pkg.sv
// Shared constants, FSM encoding and filter helper for the red-target
// tracking path (search stage and coordinate stage).
package red_track_coord_pkg;

  localparam int IMG_W_DEF       = 180;
  localparam int IMG_H_DEF       = 120;
  localparam int LOST_FRAMES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_FILTER,
    ST_HOLD
  } trk_state_t;

  // (3*old + raw + 2) >> 2, rounded IIR step
  function automatic logic [7:0] iir_mix(
    input logic [7:0] old_v,
    input logic [7:0] raw_v
  );
    logic [9:0] acc;
    acc = {2'b00, old_v} * 10'd3
        + {2'b00, raw_v}
        + 10'd2;
    return acc[9:2];
  endfunction

endpackage

// File: rtl/addr_div_seq.sv
// Iterative divider: one subtraction of DIVISOR per cycle.
// Ports: clk/rst_n, start+dividend in; busy, done, quotient, remainder out.
module addr_div_seq #(
  parameter int DIVISOR = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder
);

  localparam logic [15:0] DIV = 16'(DIVISOR);

  logic [15:0] rem;
  logic        below;

  assign below     = rem < DIV;
  // done is the cycle the remainder has settled below the divisor
  assign done      = busy & below;
  assign remainder = rem[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      quotient <= 8'd0;
      rem      <= 16'd0;
    end else if (start) begin
      busy     <= 1'b1;
      quotient <= 8'd0;
      rem      <= dividend;
    end else if (busy) begin
      if (below) begin
        busy <= 1'b0;
      end else begin
        rem      <= rem - DIV;
        quotient <= quotient + 8'd1;
      end
    end
  end

endmodule

// File: rtl/red_track_coord.sv
// Converts a red-point linear address into a filtered (x,y) target
// coordinate once per field, with lost-target and overrun reporting.
// Ports: clk_llc8, resetx, oddframe, point_addr in;
//        coord_x/coord_y/coord_valid (ready handshake), target_lost, overrun out.
module red_track_coord
  import red_track_coord_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int LOST_FRAMES = LOST_FRAMES_DEF
) (
  input  logic        clk_llc8,
  input  logic        resetx,
  input  logic        oddframe,
  input  logic [15:0] point_addr,
  output logic [7:0]  coord_x,
  output logic [7:0]  coord_y,
  output logic        coord_valid,
  input  logic        coord_ready,
  output logic        target_lost,
  output logic        overrun
);

  localparam logic [15:0] AREA   = 16'(IMG_W * IMG_H);
  localparam logic [3:0]  LOST_N = 4'(LOST_FRAMES);

  trk_state_t  state, state_n;
  logic        odd_r;
  logic        field_end;
  logic [15:0] work, work_n;
  logic [7:0]  cx, cx_n;
  logic [7:0]  cy, cy_n;
  logic        cv, cv_n;
  logic        lost, lost_n;
  logic        ovr, ovr_n;
  logic [3:0]  miss, miss_n;
  logic [3:0]  miss_inc;
  logic        hit, hit_n;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [7:0]  raw_y;
  logic [7:0]  raw_x;

  // field end: registered field flag is about to fall this edge
  assign field_end = odd_r & ~oddframe;

  assign miss_inc = (miss == 4'hF) ? miss : miss + 4'd1;

  assign coord_x     = cx;
  assign coord_y     = cy;
  assign coord_valid = cv;
  assign target_lost = lost;
  assign overrun     = ovr;

  addr_div_seq #(
    .DIVISOR(IMG_W)
  ) u_div (
    .clk      (clk_llc8),
    .rst_n    (resetx),
    .start    (div_start),
    .dividend (work),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (raw_y),
    .remainder(raw_x)
  );

  always_ff @(posedge clk_llc8 or negedge resetx) begin
    if (!resetx) begin
      state <= ST_IDLE;
      odd_r <= 1'b0;
      work  <= 16'd0;
      cx    <= 8'd0;
      cy    <= 8'd0;
      cv    <= 1'b0;
      lost  <= 1'b1;
      ovr   <= 1'b0;
      miss  <= 4'd0;
      hit   <= 1'b0;
    end else begin
      state <= state_n;
      odd_r <= oddframe;
      work  <= work_n;
      cx    <= cx_n;
      cy    <= cy_n;
      cv    <= cv_n;
      lost  <= lost_n;
      ovr   <= ovr_n;
      miss  <= miss_n;
      hit   <= hit_n;
    end
  end

  always_comb begin
    state_n   = state;
    work_n    = work;
    cx_n      = cx;
    cy_n      = cy;
    cv_n      = cv;
    lost_n    = lost;
    miss_n    = miss;
    hit_n     = hit;
    ovr_n     = 1'b0;
    div_start = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (field_end) begin
          work_n  = point_addr;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (work == 16'd0 || work >= AREA) begin
          miss_n  = miss_inc;
          if (miss_inc >= LOST_N) lost_n = 1'b1;
          state_n = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_n   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_n = ST_FILTER;
        end else if (!div_busy) begin
          state_n = ST_IDLE;
        end
      end
      ST_FILTER: begin
        // fresh acquisition snaps to the raw point
        if (lost || !hit) begin
          cx_n = raw_x;
          cy_n = raw_y;
        end else begin
          cx_n = iir_mix(cx, raw_x);
          cy_n = iir_mix(cy, raw_y);
        end
        hit_n   = 1'b1;
        lost_n  = 1'b0;
        miss_n  = 4'd0;
        cv_n    = 1'b1;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (cv && coord_ready) begin
          cv_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // busy: field end is dropped, only flagged
    if (field_end && state != ST_IDLE) ovr_n = 1'b1;
  end

endmodule

// File: tb/tb_red_track_coord.sv
// Directed and random field sequences for red_track_coord,
// checked against an arithmetic reference model.
module tb_red_track_coord;

  localparam int W     = 180;
  localparam int H     = 120;
  localparam int LOSTN = 8;

  logic        clk_llc8 = 1'b0;
  logic        resetx;
  logic        oddframe;
  logic [15:0] point_addr;
  logic        coord_ready;
  logic [7:0]  coord_x;
  logic [7:0]  coord_y;
  logic        coord_valid;
  logic        target_lost;
  logic        overrun;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  int m_x, m_y, m_miss;
  bit m_lost, m_hit;

  always #5 clk_llc8 = ~clk_llc8;

  red_track_coord dut (
    .clk_llc8   (clk_llc8),
    .resetx     (resetx),
    .oddframe   (oddframe),
    .point_addr (point_addr),
    .coord_x    (coord_x),
    .coord_y    (coord_y),
    .coord_valid(coord_valid),
    .coord_ready(coord_ready),
    .target_lost(target_lost),
    .overrun    (overrun)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int mix(input int o, input int r);
    return ((3 * o + r + 2) >> 2) & 255;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_miss = 0;
    m_lost = 1; m_hit = 0;
  endtask

  task automatic model_miss();
    if (m_miss < 15) m_miss++;
    if (m_miss >= LOSTN) m_lost = 1;
  endtask

  task automatic model_hit(input int addr);
    int rx, ry;
    rx = addr % W;
    ry = addr / W;
    if (m_lost || !m_hit) begin
      m_x = rx; m_y = ry;
    end else begin
      m_x = mix(m_x, rx); m_y = mix(m_y, ry);
    end
    m_hit = 1; m_lost = 0; m_miss = 0;
  endtask

  function automatic int bad_addr();
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(W * H, 65535));
  endfunction

  task automatic field_fall(input int addr);
    @(posedge clk_llc8); #1;
    point_addr = 16'(addr);
    oddframe   = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (coord_valid !== 1'b1 && lat < 400) begin
      @(posedge clk_llc8); #1;
      lat++;
    end
  endtask

  task automatic do_hit(input int addr);
    int lat;
    model_hit(addr);
    field_fall(addr);
    wait_valid(lat);
    oddframe = 1'b1;
    check("latency", lat, (addr / W) + 4);
    check("hit_x", coord_x, m_x);
    check("hit_y", coord_y, m_y);
    check("hit_lost", target_lost, 0);
    @(posedge clk_llc8); #1;
    check("valid_drop", coord_valid, 0);
  endtask

  task automatic do_miss(input int addr);
    int seen;
    seen = 0;
    model_miss();
    field_fall(addr);
    repeat (6) begin
      @(posedge clk_llc8); #1;
      if (coord_valid !== 1'b0) seen++;
    end
    oddframe = 1'b1;
    check("miss_novalid", seen, 0);
    check("miss_lost", target_lost, m_lost);
    check("miss_x", coord_x, m_x);
    check("miss_y", coord_y, m_y);
  endtask

  initial begin
    int lat, bad;
    resetx      = 1'b0;
    oddframe    = 1'b1;
    point_addr  = 16'd0;
    coord_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_llc8);
    #1;
    check("rst_x", coord_x, 0);
    check("rst_y", coord_y, 0);
    check("rst_valid", coord_valid, 0);
    check("rst_lost", target_lost, 1);
    check("rst_overrun", overrun, 0);
    resetx = 1'b1;

    // empty fields straight after reset
    repeat (8) do_miss(0);

    // first acquisition, then filtered follow-up
    do_hit(1000);
    check("first_x", coord_x, 100);
    check("first_y", coord_y, 5);
    do_hit(1004);
    check("filt_x", coord_x, 101);
    check("filt_y", coord_y, 5);

    // consumer stalls; second field end arrives in HOLD
    coord_ready = 1'b0;
    model_hit(1000);
    field_fall(1000);
    wait_valid(lat);
    oddframe = 1'b1;
    check("stall_latency", lat, 9);
    check("stall_x", coord_x, m_x);
    bad = 0;
    repeat (20) begin
      @(posedge clk_llc8); #1;
      if (coord_valid !== 1'b1 || coord_x !== 8'(m_x)
          || coord_y !== 8'(m_y)) bad++;
    end
    check("hold_stable", bad, 0);
    field_fall(500);
    @(posedge clk_llc8); #1;
    check("overrun_pulse", overrun, 1);
    @(posedge clk_llc8); #1;
    check("overrun_end", overrun, 0);
    oddframe = 1'b1;
    check("ovr_valid", coord_valid, 1);
    check("ovr_x", coord_x, m_x);
    check("ovr_y", coord_y, m_y);
    coord_ready = 1'b1;
    @(posedge clk_llc8); #1;
    check("stall_release", coord_valid, 0);

    // lose the target, then reacquire at the far corner
    repeat (LOSTN) do_miss(bad_addr());
    check("lost_after8", target_lost, 1);
    do_hit(21419);
    check("corner_x", coord_x, 179);
    check("corner_y", coord_y, 118);

    // random field sequence
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) do_miss(bad_addr());
      else do_hit(int'($urandom_range(1, W * H - 1)));
    end

    // reset in the middle of a long divide
    field_fall(21419);
    repeat (20) @(posedge clk_llc8);
    #1;
    resetx = 1'b0;
    #1;
    model_reset();
    check("mid_rst_x", coord_x, 0);
    check("mid_rst_y", coord_y, 0);
    check("mid_rst_valid", coord_valid, 0);
    check("mid_rst_lost", target_lost, 1);
    check("mid_rst_ovr", overrun, 0);
    repeat (3) @(posedge clk_llc8);
    #1;
    oddframe = 1'b1;
    resetx   = 1'b1;
    bad = 0;
    repeat (150) begin
      @(posedge clk_llc8); #1;
      if (coord_valid !== 1'b0) bad++;
    end
    check("no_valid_after_rst", bad, 0);
    do_hit(1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
